// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// seq_detector_param : serial PAT_W-bit pattern detector, overlap/non-overlap,
// saturating match counter. Optional macro MATCH_MASK_EN adds pattern_mask.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          x_in,
  input  logic                          x_valid,
  input  logic                          overlap_en,
  input  logic                          clear,
`ifdef MATCH_MASK_EN
  input  logic [PAT_W-1:0]              pattern_mask,
`endif
  output logic                          match,
  output logic [$clog2(PAT_W+1)-1:0]    fill,
  output logic [CNT_W-1:0]              match_count,
  output logic                          count_sat
);

  localparam int              FILL_W      = $clog2(PAT_W+1);
  localparam logic [FILL_W-1:0] C_FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q,   fill_d;
  logic              match_q,  match_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              sat_q,    sat_d;

  logic [PAT_W-1:0]  w_win_n;
  logic [FILL_W-1:0] w_fill_n;
  logic [PAT_W-1:0]  w_mask;
  logic              w_hit;

`ifdef MATCH_MASK_EN
  assign w_mask = pattern_mask;
`else
  assign w_mask = '1;
`endif

  always_comb begin
    w_win_n  = {window_q[PAT_W-2:0], x_in};
    w_fill_n = (fill_q == C_FILL_FULL) ? C_FILL_FULL : fill_q + FILL_W'(1);
    w_hit    = (w_fill_n == C_FILL_FULL) && (((w_win_n ^ PATTERN) & w_mask) == '0);
  end

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    count_d  = count_q;
    if (clear) begin
      window_d = '0;
      fill_d   = '0;
      count_d  = '0;
    end else if (x_valid) begin
      window_d = w_win_n;
      match_d  = w_hit;
      // Non-overlap restart only needs fill cleared; stale window bits age out.
      fill_d   = (w_hit && !overlap_en) ? '0 : w_fill_n;
      if (w_hit && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
    end
    sat_d = (count_d == '1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window_q <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  assign match       = match_q;
  assign fill        = fill_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
//------------------------------------------------------------------------------
// tb_seq_detector_param : scoreboard bench for two detector configurations
// (1011/CNT_W=8 and 1111/CNT_W=2) fed from the same input stream.
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_seq_detector_param;

  logic       clock;
  logic       reset;
  logic       x_in;
  logic       x_valid;
  logic       overlap_en;
  logic       clear;
`ifdef MATCH_MASK_EN
  logic [3:0] pattern_mask;
`endif

  logic       match0, sat0, match1, sat1;
  logic [2:0] fill0, fill1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut0 (
    .clock       (clock),
    .reset       (reset),
    .x_in        (x_in),
    .x_valid     (x_valid),
    .overlap_en  (overlap_en),
    .clear       (clear),
`ifdef MATCH_MASK_EN
    .pattern_mask(pattern_mask),
`endif
    .match       (match0),
    .fill        (fill0),
    .match_count (cnt0),
    .count_sat   (sat0)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) u_dut1 (
    .clock       (clock),
    .reset       (reset),
    .x_in        (x_in),
    .x_valid     (x_valid),
    .overlap_en  (overlap_en),
    .clear       (clear),
`ifdef MATCH_MASK_EN
    .pattern_mask(4'b1111),
`endif
    .match       (match1),
    .fill        (fill1),
    .match_count (cnt1),
    .count_sat   (sat1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int m[2];
    int f[2];
    int c[2];
    int s[2];
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: history as an integer of the last 4 consumed bits plus
  // a count of how many of them belong to the current attempt.
  int hv[2];
  int len[2];
  int cnt[2];
  int mt[2];
  int pat[2]  = '{11, 15};
  int cmax[2] = '{255, 3};
  int msk[2]  = '{15, 15};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hv[k] = 0; len[k] = 0; cnt[k] = 0; mt[k] = 0;
    end
  endtask

  task automatic model_edge(input bit v, input bit x, input bit ov, input bit clr);
    bit hit;
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        hv[k] = 0; len[k] = 0; cnt[k] = 0; mt[k] = 0;
      end else if (v) begin
        hv[k]  = (hv[k] * 2 + int'(x)) % 16;
        len[k] = (len[k] + 1 > 4) ? 4 : len[k] + 1;
        hit    = (len[k] == 4) && (((hv[k] ^ pat[k]) & msk[k]) == 0);
        mt[k]  = hit ? 1 : 0;
        if (hit) begin
          cnt[k] = (cnt[k] + 1 > cmax[k]) ? cmax[k] : cnt[k] + 1;
          if (!ov) len[k] = 0;
        end
      end else begin
        mt[k] = 0;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.m[k] = mt[k];
      e.f[k] = len[k];
      e.c[k] = cnt[k];
      e.s[k] = (cnt[k] == cmax[k]) ? 1 : 0;
    end
    sbq.push_back(e);
  endtask

  task automatic step(input bit v, input bit x, input bit ov, input bit clr);
    @(negedge clock);
    x_valid    = v;
    x_in       = x;
    overlap_en = ov;
    clear      = clr;
    model_edge(v, x, ov, clr);
    push_expected();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_match0"}, int'(match0), 0);
    chk({tag, "_fill0"},  int'(fill0),  0);
    chk({tag, "_cnt0"},   int'(cnt0),   0);
    chk({tag, "_sat0"},   int'(sat0),   0);
    chk({tag, "_match1"}, int'(match1), 0);
    chk({tag, "_fill1"},  int'(fill1),  0);
    chk({tag, "_cnt1"},   int'(cnt1),   0);
    chk({tag, "_sat1"},   int'(sat1),   0);
  endtask

  // Asynchronous reset asserted in the middle of the high phase.
  task automatic mid_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clock);
    x_valid = 1'b0;
    clear   = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic stream(input bit [15:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0);
  endtask

  // Monitor: every edge that had stimulus queued is checked 1 ns after it.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("match0", int'(match0), e.m[0]);
      chk("fill0",  int'(fill0),  e.f[0]);
      chk("count0", int'(cnt0),   e.c[0]);
      chk("sat0",   int'(sat0),   e.s[0]);
      chk("match1", int'(match1), e.m[1]);
      chk("fill1",  int'(fill1),  e.f[1]);
      chk("count1", int'(cnt1),   e.c[1]);
      chk("sat1",   int'(sat1),   e.s[1]);
    end
  end

  initial begin
    reset      = 1'b0;
    x_in       = 1'b0;
    x_valid    = 1'b0;
    overlap_en = 1'b1;
    clear      = 1'b0;
`ifdef MATCH_MASK_EN
    pattern_mask = 4'b1111;
`endif
    model_reset();
    #1;
    check_all_zero("por");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Overlapping: pulses after bits 4 and 7.
    stream(16'b1011011, 7, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Non-overlapping: single pulse, fill ends at 3.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    stream(16'b1011011, 7, 1'b0);

    // Valid gaps with x_in toggling while unqualified.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      for (int g = 0; g < 3; g++) step(1'b0, g[0], 1'b1, 1'b0);
    end

    // Mid-stream reset with fill=3, then a full pattern is needed again.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    stream(16'b101, 3, 1'b1);
    mid_reset();
    stream(16'b1011, 4, 1'b1);

    // Saturation of the 2-bit counter on the all-ones instance.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    stream(16'hFF, 8, 1'b1);

    // Clear on the edge that would complete 1011.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    stream(16'b101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef MATCH_MASK_EN
    step(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    pattern_mask = 4'b1001;
    msk[0] = 9;
    stream(16'b1101, 4, 1'b1);
    @(negedge clock);
    pattern_mask = 4'b1111;
    msk[0] = 15;
`endif

    // Randomised traffic, mostly valid, occasional clear and overlap flips.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0);
`ifdef MATCH_MASK_EN
      if (i == 300) begin
        @(negedge clock);
        pattern_mask = 4'b0110;
        msk[0] = 6;
      end
`endif
    end

    @(negedge clock);
    x_valid = 1'b0;
    clear   = 1'b0;
    repeat (3) @(negedge clock);
    chk("scoreboard_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
